layer_merge_scanner: RTL

LAYER_MERGE_SCANNER -- requirements
Module: layer_merge_scanner

---
 rtl/layer_merge_scanner.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/layer_merge_scanner.sv
// Merges LAYERS bit-plane frames (OR/XOR/AND) into a shadow buffer and row-scans a display buffer onto row_sel/col_data.
// Latency: load captures at that edge (pending next cycle); row_sel/col_data are registered, valid one cycle after the state change.
// No backpressure: load is always accepted; the shadow is committed at frame end while scanning, or on the next edge when idle.
module layer_merge_scanner #(
    parameter int ROWS     = 8,
    parameter int COLS     = 8,
    parameter int LAYERS   = 2,
    parameter int SCAN_DIV = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [LAYERS*ROWS*COLS-1:0]   layers_flat,
    input  logic [LAYERS-1:0]             layer_en,
    input  logic [1:0]                    mode,
    input  logic                          load,
    input  logic                          enable,
    output logic [ROWS-1:0]               row_sel,
    output logic [COLS-1:0]               col_data,
    output logic                          frame_done,
    output logic                          pending
);

    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t          state, state_nxt;
    logic [RW-1:0]   row_idx, row_nxt;
    logic [DW-1:0]   div_cnt, div_nxt;
    logic            commit;
    logic            frame_done_nxt;
    logic            pending_nxt;
    logic [ROWS-1:0] row_sel_nxt;
    logic [COLS-1:0] col_data_nxt;
    logic [COLS-1:0] acc;
    logic [COLS-1:0] lv;

    logic [COLS-1:0] merged      [ROWS];
    logic [COLS-1:0] shadow      [ROWS];
    logic [COLS-1:0] display     [ROWS];
    logic [COLS-1:0] display_nxt [ROWS];

    // Bitwise merge of enabled layers per row; AND starts from all-ones so a disabled layer zeroes the result.
    always_comb begin
        acc = '0;
        lv  = '0;
        for (int r = 0; r < ROWS; r++) begin
            acc = (mode == 2'b10) ? {COLS{1'b1}} : {COLS{1'b0}};
            for (int l = 0; l < LAYERS; l++) begin
                lv = layer_en[l] ? layers_flat[(l*ROWS + r)*COLS +: COLS] : {COLS{1'b0}};
                case (mode)
                    2'b01:   acc = acc ^ lv;
                    2'b10:   acc = acc & lv;
                    default: acc = acc | lv;
                endcase
            end
            merged[r] = acc;
        end
    end

    // Next-state, scan counters, commit decision and the registered-output next values.
    always_comb begin
        state_nxt      = state;
        row_nxt        = row_idx;
        div_nxt        = div_cnt;
        frame_done_nxt = 1'b0;
        commit         = 1'b0;
        case (state)
            IDLE: begin
                commit = pending;
                if (enable) begin
                    state_nxt = SCAN;
                    row_nxt   = '0;
                    div_nxt   = '0;
                end
            end
            SCAN: begin
                if (!enable) begin
                    // Mid-frame exit drops the scan position; pending is left for the idle commit.
                    state_nxt = IDLE;
                    row_nxt   = '0;
                    div_nxt   = '0;
                end else if (div_cnt == DW'(SCAN_DIV - 1)) begin
                    div_nxt = '0;
                    if (row_idx == RW'(ROWS - 1)) begin
                        row_nxt        = '0;
                        frame_done_nxt = 1'b1;
                        commit         = pending;
                    end else begin
                        row_nxt = row_idx + 1'b1;
                    end
                end else begin
                    div_nxt = div_cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // A load on the commit edge refills the shadow after the old one is taken, so pending stays set.
        pending_nxt = load ? 1'b1 : (commit ? 1'b0 : pending);

        for (int r = 0; r < ROWS; r++) begin
            display_nxt[r] = commit ? shadow[r] : display[r];
        end

        // Outputs are derived from next-cycle values so col_data always matches display[row index].
        row_sel_nxt  = '0;
        col_data_nxt = '0;
        if (state_nxt == SCAN) begin
            row_sel_nxt[row_nxt] = 1'b1;
            col_data_nxt         = display_nxt[row_nxt];
        end
    end

    // State register and scan counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            row_idx <= '0;
            div_cnt <= '0;
        end else begin
            state   <= state_nxt;
            row_idx <= row_nxt;
            div_cnt <= div_nxt;
        end
    end

    // Shadow capture on load, display update on commit, pending flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending <= 1'b0;
            for (int r = 0; r < ROWS; r++) begin
                shadow[r]  <= '0;
                display[r] <= '0;
            end
        end else begin
            pending <= pending_nxt;
            for (int r = 0; r < ROWS; r++) begin
                display[r] <= display_nxt[r];
                if (load) begin
                    shadow[r] <= merged[r];
                end
            end
        end
    end

    // Registered display drive and frame-end pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row_sel    <= '0;
            col_data   <= '0;
            frame_done <= 1'b0;
        end else begin
            row_sel    <= row_sel_nxt;
            col_data   <= col_data_nxt;
            frame_done <= frame_done_nxt;
        end
    end

endmodule
